// File: rtl/instr_queue_splitter_if.sv
// ============================================================================
// Module   : instr_queue_splitter_if
// Brief    : Fetch/decode handshake bundle with split head-entry fields.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_queue_splitter_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [PC_W-1:0]   out_pc;
    logic [5:0]        Op;
    logic [4:0]        A1;
    logic [4:0]        A2;
    logic [4:0]        A3;
    logic [4:0]        Shamt;
    logic [5:0]        Funct;
    logic [15:0]       Offset;
    logic [25:0]       Instr_Index;
    logic              is_rtype;
    logic              is_jtype;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, Op, A1, A2, A3, Shamt,
               Funct, Offset, Instr_Index, is_rtype, is_jtype, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, Op, A1, A2, A3, Shamt,
               Funct, Offset, Instr_Index, is_rtype, is_jtype, count
    );
endinterface

`default_nettype wire

// File: rtl/instr_queue_splitter.sv
// ============================================================================
// Module   : instr_queue_splitter
// Brief    : Instruction/PC FIFO between fetch and decode; head split into
//            MIPS fields. Optional same-cycle bypass: INSTR_QUEUE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_queue_splitter #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              flush,
    instr_queue_splitter_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic [31:0]      r_instr [DEPTH];
    logic [PC_W-1:0]  r_pc    [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_instr;
    logic [PC_W-1:0]  w_head_pc;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

`ifdef INSTR_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & bus.in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction taken by decode in the same cycle is never stored.
    assign w_push = bus.in_valid & ~w_full & ~(w_bypass & bus.out_ready);
    assign w_pop  = ~w_empty & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
        end else if (w_push && !flush) begin
            r_instr[r_wr_ptr] <= bus.in_instr;
            r_pc[r_wr_ptr]    <= bus.in_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Head is zeroed when nothing valid is presented so stale storage never leaks.
    assign w_head_instr = w_bypass ? bus.in_instr : (w_empty ? 32'd0 : r_instr[r_rd_ptr]);
    assign w_head_pc    = w_bypass ? bus.in_pc    : (w_empty ? '0    : r_pc[r_rd_ptr]);

    assign bus.in_ready    = ~w_full;
    assign bus.out_valid   = ~w_empty | w_bypass;
    assign bus.out_instr   = w_head_instr;
    assign bus.out_pc      = w_head_pc;
    assign bus.Op          = w_head_instr[31:26];
    assign bus.A1          = w_head_instr[25:21];
    assign bus.A2          = w_head_instr[20:16];
    assign bus.A3          = w_head_instr[15:11];
    assign bus.Shamt       = w_head_instr[10:6];
    assign bus.Funct       = w_head_instr[5:0];
    assign bus.Offset      = w_head_instr[15:0];
    assign bus.Instr_Index = w_head_instr[25:0];
    assign bus.is_rtype    = (w_head_instr[31:26] == 6'h00);
    assign bus.is_jtype    = (w_head_instr[31:26] == 6'h02) || (w_head_instr[31:26] == 6'h03);
    assign bus.count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_queue_splitter.sv
// ============================================================================
// Module   : tb_instr_queue_splitter
// Brief    : Scoreboard bench for instr_queue_splitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_queue_splitter;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    instr_queue_splitter_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus();

    instr_queue_splitter #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_pc = pc; bus.out_ready = 1'b0;
        sb.push_back({instr, pc});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.Op !== 6'd0) begin n_bad++; $display("FAIL reset_op got %h want 0", bus.Op); end
        n_cmp++; if (bus.Instr_Index !== 26'd0) begin n_bad++; $display("FAIL reset_index got %h want 0", bus.Instr_Index); end
    endtask

    task automatic test_fields();
        logic [63:0] exp;
        push_one(32'h012A_4020, 32'h0000_3000);
        #1;
        n_cmp++; if (bus.Op !== 6'h00) begin n_bad++; $display("FAIL fld_op got %h want 00", bus.Op); end
        n_cmp++; if (bus.A1 !== 5'd9) begin n_bad++; $display("FAIL fld_a1 got %0d want 9", bus.A1); end
        n_cmp++; if (bus.A2 !== 5'd10) begin n_bad++; $display("FAIL fld_a2 got %0d want 10", bus.A2); end
        n_cmp++; if (bus.A3 !== 5'd8) begin n_bad++; $display("FAIL fld_a3 got %0d want 8", bus.A3); end
        n_cmp++; if (bus.Shamt !== 5'd0) begin n_bad++; $display("FAIL fld_shamt got %0d want 0", bus.Shamt); end
        n_cmp++; if (bus.Funct !== 6'h20) begin n_bad++; $display("FAIL fld_funct got %h want 20", bus.Funct); end
        n_cmp++; if (bus.Offset !== 16'h4020) begin n_bad++; $display("FAIL fld_offset got %h want 4020", bus.Offset); end
        n_cmp++; if (bus.is_rtype !== 1'b1) begin n_bad++; $display("FAIL fld_rtype got %b want 1", bus.is_rtype); end
        n_cmp++; if (bus.is_jtype !== 1'b0) begin n_bad++; $display("FAIL fld_jtype got %b want 0", bus.is_jtype); end
        n_cmp++; if (bus.out_pc !== 32'h3000) begin n_bad++; $display("FAIL fld_pc got %h want 3000", bus.out_pc); end
        n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL fld_count got %0d want 1", bus.count); end
        bus.out_ready = 1'b1;
        #1;
        exp = sb.pop_front();
        n_cmp++; if (!bus.out_valid || {bus.out_instr, bus.out_pc} !== exp) begin n_bad++; $display("FAIL fld_pop got %h want %h", {bus.out_instr, bus.out_pc}, exp); end
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL fld_drained got %0d want 0", bus.count); end
    endtask

    task automatic test_full();
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) push_one(32'h2000_0000 + i, 32'h100 + 4 * i);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", bus.count); end
        bus.in_valid = 1'b1; bus.in_instr = 32'hDEAD_0005; bus.in_pc = 32'h200;
        tick();
        n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_5th_ignored got %0d want 4", bus.count); end
        // Push with pop on a full queue: only the pop takes effect.
        bus.in_instr = 32'hDEAD_0006; bus.out_ready = 1'b1;
        #1;
        exp = sb.pop_front();
        n_cmp++; if (!bus.out_valid || {bus.out_instr, bus.out_pc} !== exp) begin n_bad++; $display("FAIL full_pp_head got %h want %h", {bus.out_instr, bus.out_pc}, exp); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL full_pp_count got %0d want 3", bus.count); end
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = sb.pop_front();
            n_cmp++; if (!bus.out_valid || {bus.out_instr, bus.out_pc} !== exp) begin n_bad++; $display("FAIL drain_%0d got %h want %h", i, {bus.out_instr, bus.out_pc}, exp); end
            tick();
        end
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL drain_count got %0d want 0", bus.count); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp;
        push_one(32'h3000_00FF, 32'h500);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = 32'h3000_0000 + i; bus.in_pc = 32'h600 + 4 * i;
            bus.out_ready = 1'b1;
            sb.push_back({bus.in_instr, bus.in_pc});
            #1;
            exp = sb.pop_front();
            n_cmp++; if (!bus.out_valid || {bus.out_instr, bus.out_pc} !== exp) begin n_bad++; $display("FAIL wrap_head_%0d got %h want %h", i, {bus.out_instr, bus.out_pc}, exp); end
            tick();
            n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL wrap_count_%0d got %0d want 1", i, bus.count); end
        end
        bus.in_valid = 1'b0;
        #1;
        exp = sb.pop_front();
        n_cmp++; if (!bus.out_valid || {bus.out_instr, bus.out_pc} !== exp) begin n_bad++; $display("FAIL wrap_last got %h want %h", {bus.out_instr, bus.out_pc}, exp); end
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL wrap_empty got %0d want 0", bus.count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_one(32'h4000_0000 + i, 32'h700 + 4 * i);
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h0C00_0C00; bus.in_pc = 32'h800;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        sb.delete();
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready_toggle got count %0d ready %b want 0/1", bus.count, bus.in_ready); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) push_one(32'h5000_0000 + i, 32'h900 + 4 * i);
        n_cmp++; if (bus.count !== 3'd2) begin n_bad++; $display("FAIL arst_pre_count got %0d want 2", bus.count); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL arst_count got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_instr !== 32'd0) begin n_bad++; $display("FAIL arst_instr got %h want 0", bus.out_instr); end
        #2 reset_n = 1'b1;
        sb.delete();
        tick();
    endtask

    task automatic test_bypass();
        bus.in_valid = 1'b1; bus.in_instr = 32'h0800_0C00; bus.in_pc = 32'hA00; bus.out_ready = 1'b1;
        #1;
`ifdef INSTR_QUEUE_BYPASS_EN
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL byp_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.is_jtype !== 1'b1) begin n_bad++; $display("FAIL byp_jtype got %b want 1", bus.is_jtype); end
        n_cmp++; if (bus.Instr_Index !== 26'h0000C00) begin n_bad++; $display("FAIL byp_index got %h want 0000c00", bus.Instr_Index); end
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL byp_count got %0d want 0", bus.count); end
`else
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_same_cycle got %b want 0", bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_next got count %0d valid %b want 1/1", bus.count, bus.out_valid); end
        n_cmp++; if (bus.is_jtype !== 1'b1 || bus.Instr_Index !== 26'h0000C00) begin n_bad++; $display("FAIL lat_fields got j %b idx %h want 1/0000c00", bus.is_jtype, bus.Instr_Index); end
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL lat_drain got %0d want 0", bus.count); end
`endif
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_fields();
        test_full();
        test_wrap();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/instr_queue_splitter.md
Name: instr_queue_splitter

Overview:
- Parametrised instruction queue that buffers fetched MIPS instructions and their PCs.
- Presents the head entry already split into its fields (Op, Funct, Shamt, A1/A2/A3, Offset, Instr_Index) plus format flags.
- Sits between fetch and decode and decouples fetch from decode stalls through a valid/ready handshake.
- Supports a flush on branch or jump redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PC_W, 32, width of the PC stored alongside each instruction.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous queue clear.
- in_valid  input  1  fetch presents an instruction.
- in_instr  input  32  instruction word.
- in_pc  input  PC_W  PC of in_instr.
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  PC_W  head PC.
- Op  output  6  head[31:26].
- A1  output  5  head[25:21].
- A2  output  5  head[20:16].
- A3  output  5  head[15:11].
- Shamt  output  5  head[10:6].
- Funct  output  6  head[5:0].
- Offset  output  16  head[15:0].
- Instr_Index  output  26  head[25:0].
- is_rtype  output  1  Op == 6'h00.
- is_jtype  output  1  Op == 6'h02 or Op == 6'h03.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; all storage entries are cleared to 0.
  - out_valid=0, in_ready=1; all field outputs are 0.
- Push: in_valid && in_ready at a clock edge.
  - Writes {in_instr, in_pc} to entry wr_ptr.
  - wr_ptr increments modulo DEPTH, with natural wrap-around.
- Pop: out_valid && out_ready at a clock edge.
  - rd_ptr increments modulo DEPTH.
- Occupancy:
  - in_ready = (count != DEPTH). A full queue accepts no push, even when a pop occurs in the same cycle.
  - out_valid = (count != 0).
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Latency: an instruction pushed at edge N appears at the head at N+1 if the queue was empty; there is no combinational in-to-out path.
- Head outputs:
  - Field outputs are combinational slices of the head entry (entry rd_ptr).
  - When count==0 all field outputs, out_instr and out_pc are forced to 0; consumers ignore them while out_valid=0.
- Flush (synchronous):
  - At the next edge, pointers and count go to 0.
  - Flush has priority over a push or pop in the same cycle; that push is dropped.
  - Storage is not cleared by flush.
- Reset asserted mid-operation: the queue empties immediately and asynchronously; no partial entry survives.
- A change on out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1 and flush=0, the head outputs show in_instr/in_pc combinationally and out_valid=1 in the same cycle.
  - If out_ready=1 in that cycle, the instruction is consumed without being stored; pointers and count are unchanged.
  - If out_ready=0, it is pushed normally.
- Undefined: no bypass path; minimum latency is 1 cycle as above.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, count=0, Op=0, Instr_Index=0.
- Push 0x012A4020 (add $t0,$t1,$t2) at PC 0x3000 with out_ready=0; next cycle:
  - Op=0, A1=9, A2=10, A3=8, Shamt=0, Funct=0x20.
  - is_rtype=1, out_pc=0x3000, count=1.
- Push 4 entries with DEPTH=4 and out_ready=0:
  - After the 4th, in_ready=0 and a 5th push is ignored (count stays 4).
  - Drain with out_ready=1 gives entries in FIFO order, and out_valid drops after the 4th pop.
- Pointer wrap-around: push and pop continuously for 10 instructions with simultaneous push/pop.
  - count stays at 1.
  - Output order matches input order across the wrap.
- Flush with count=3 while in_valid=1 and in_instr=0x0C000C00 (jal): next cycle count=0, out_valid=0, and the jal is not queued.
- Assert reset_n low mid-stream with count=2, asynchronously between edges: out_valid drops to 0 without waiting for a clock edge.
- With INSTR_QUEUE_BYPASS_EN, empty queue, push 0x08000C00 with out_ready=1:
  - Same cycle: out_valid=1, is_jtype=1, Instr_Index=0x0000C00.
  - Next cycle: count=0.
